// File: rtl/anfsqrt_isqrt_param.sv
// Iterative integer square root: STEPS root bits per clock via a chain of step units,
// valid/ready on both sides, result registers held until the next completion.

module anfsqrt_isqrt_step #(
  parameter int WIDTH = 16,
  parameter int IW    = 5
) (
  input  logic signed [IW-1:0]      idx_i,
  input  logic        [WIDTH-1:0]   eps_i,
  input  logic        [WIDTH/2-1:0] root_i,
  output logic        [WIDTH-1:0]   eps_o,
  output logic        [WIDTH/2-1:0] root_o
);
  localparam int RW = WIDTH / 2;

  logic [IW-1:0] sh;
  logic [WIDTH:0] delta;

  // A negative index means this unit lies past bit 0 in a partial last cycle.
  always_comb begin
    sh     = idx_i;
    delta  = ((WIDTH+1)'(root_i) << (sh + IW'(1))) + ((WIDTH+1)'(1) << {sh[IW-2:0], 1'b0});
    eps_o  = eps_i;
    root_o = root_i;
    if (!idx_i[IW-1] && (delta <= {1'b0, eps_i})) begin
      eps_o  = eps_i - delta[WIDTH-1:0];
      root_o = root_i | (RW'(1) << sh);
    end
  end
endmodule

module anfsqrt_isqrt_param #(
  parameter int WIDTH = 16,
  parameter int STEPS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   radicand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder
);
  localparam int RW = WIDTH / 2;
  localparam int IW = $clog2(RW) + 2;
  localparam logic signed [IW-1:0] STEPS_S = IW'(STEPS);
  localparam logic signed [IW-1:0] TOP_BIT = IW'(RW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("anfsqrt_isqrt_param: WIDTH must be even and >= 4");
  end
  if (STEPS < 1 || STEPS > WIDTH / 2) begin : g_bad_steps
    $error("anfsqrt_isqrt_param: STEPS must be in 1..WIDTH/2");
  end

  logic [1:0]              state_q, state_d;
  logic [WIDTH-1:0]        eps_q, eps_d;
  logic [RW-1:0]           acc_q, acc_d;
  logic signed [IW-1:0]    bit_q, bit_d;
  logic [RW-1:0]           root_q, root_d;
  logic [RW:0]             rem_q, rem_d;
  logic                    ov_q, ov_d;

  logic [WIDTH-1:0]        fin_eps;
  logic [RW-1:0]           fin_root;
  logic                    last;
  logic                    unused_eps;

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    localparam logic signed [IW-1:0] KOFF = IW'(k);
    logic signed [IW-1:0] idx;
    logic [WIDTH-1:0]     eps_in, eps_out;
    logic [RW-1:0]        root_in, root_out;

    assign idx = bit_q - KOFF;
    if (k == 0) begin : g_head
      assign eps_in  = eps_q;
      assign root_in = acc_q;
    end else begin : g_link
      assign eps_in  = g_step[k-1].eps_out;
      assign root_in = g_step[k-1].root_out;
    end

    anfsqrt_isqrt_step #(.WIDTH(WIDTH), .IW(IW)) u_step (
      .idx_i  (idx),
      .eps_i  (eps_in),
      .root_i (root_in),
      .eps_o  (eps_out),
      .root_o (root_out)
    );
  end

  assign fin_eps    = g_step[STEPS-1].eps_out;
  assign fin_root   = g_step[STEPS-1].root_out;
  assign last       = (bit_q < STEPS_S);
  assign unused_eps = ^fin_eps[WIDTH-1:RW+1];

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = ov_q;
  assign root      = root_q;
  assign remainder = rem_q;

  always_comb begin
    state_d = state_q;
    eps_d   = eps_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    root_d  = root_q;
    rem_d   = rem_q;
    ov_d    = ov_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          eps_d   = radicand;
          acc_d   = '0;
          bit_d   = TOP_BIT;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        eps_d = fin_eps;
        acc_d = fin_root;
        bit_d = bit_q - STEPS_S;
        if (last) begin
          root_d  = fin_root;
          rem_d   = fin_eps[RW:0];
          ov_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Transfer and a new accept may share an edge; go straight back to RUN.
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
          if (in_valid) begin
            eps_d   = radicand;
            acc_d   = '0;
            bit_d   = TOP_BIT;
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      eps_q   <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      eps_q   <= eps_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      ov_q    <= ov_d;
    end
  end
endmodule
